// File: rtl/anim_title_colorizer_if.sv
// Bundle of the video-side signals between the pixel timing/control logic and the title colorizer.
// Latency: none, wiring only.
// Backpressure: none; every signal is a free-running video stream.
interface anim_title_colorizer_if #(
    parameter int FRAME_ADDR_WIDTH = 2
);
    logic                        enable;
    logic                        frame_start;
    logic signed [31:0]          pos_x;
    logic signed [31:0]          pos_y;
    logic signed [31:0]          pixel_row;
    logic signed [31:0]          pixel_column;
    logic [11:0]                 title_color;
    logic                        title_valid;
    logic [FRAME_ADDR_WIDTH-1:0] frame_index;
    logic                        anim_done;

    modport master (
        output enable, frame_start, pos_x, pos_y, pixel_row, pixel_column,
        input  title_color, title_valid, frame_index, anim_done
    );

    modport slave (
        input  enable, frame_start, pos_x, pos_y, pixel_row, pixel_column,
        output title_color, title_valid, frame_index, anim_done
    );
endinterface

// File: rtl/anim_title_colorizer.sv
// Animated title overlay: frames stored back to back in one RAM, stepped on video-frame ticks.
// Latency: colour/valid are exactly 2 clk after the pixel coordinate (RAM read + output register).
// Backpressure: none; free-running pipeline. Define TITLE_BLINK_EN to add periodic blanking.
module anim_title_colorizer #(
    parameter string       INIT_FILE          = "title-anim.mem",
    parameter int          TITLE_ADDR_WIDTH_X = 8,
    parameter int          TITLE_ADDR_WIDTH_Y = 7,
    parameter int          NUM_FRAMES         = 4,
    parameter int          FRAME_ADDR_WIDTH   = 2,
    parameter int          FRAME_HOLD         = 8,
    parameter int          LOOP               = 1,
    parameter logic [11:0] TRANSPARENT_COLOR  = 12'hF0F,
    parameter int          DEFAULT_X          = 384,
    parameter int          DEFAULT_Y          = 32,
    parameter int          BLINK_PERIOD       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    anim_title_colorizer_if.slave bus
);
    localparam int ADDR_W = FRAME_ADDR_WIDTH + TITLE_ADDR_WIDTH_Y + TITLE_ADDR_WIDTH_X;
    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic signed [31:0]          TITLE_W    = 32'(2 ** TITLE_ADDR_WIDTH_X);
    localparam logic signed [31:0]          TITLE_H    = 32'(2 ** TITLE_ADDR_WIDTH_Y);
    localparam logic [FRAME_ADDR_WIDTH-1:0] LAST_FRAME = FRAME_ADDR_WIDTH'(NUM_FRAMES - 1);
    localparam logic [HOLD_W-1:0]           LAST_HOLD  = HOLD_W'(FRAME_HOLD - 1);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t                      state;
    logic [FRAME_ADDR_WIDTH-1:0] frame_index;
    logic [HOLD_W-1:0]           hold;
    logic                        anim_done;
    logic signed [31:0]          lat_x;
    logic signed [31:0]          lat_y;
    logic signed [31:0]          adj_row;
    logic signed [31:0]          adj_col;
    logic                        in_bounds;
    logic [ADDR_W-1:0]           read_addr;
    logic [11:0]                 mem [0:(2**ADDR_W)-1];
    logic [11:0]                 q;
    logic                        s1_in_bounds;
    logic                        valid_next;
    logic                        blink_off;
    logic [11:0]                 title_color;
    logic                        title_valid;

    // Animation sequencer: frame index only moves on frame_start so a scan never mixes frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            frame_index <= '0;
            hold        <= '0;
            anim_done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    frame_index <= '0;
                    hold        <= '0;
                    anim_done   <= 1'b0;
                    if (bus.enable) state <= PLAY;
                end
                PLAY: begin
                    if (!bus.enable) begin
                        state       <= IDLE;
                        frame_index <= '0;
                        hold        <= '0;
                    end else if (bus.frame_start) begin
                        if (hold == LAST_HOLD) begin
                            hold <= '0;
                            if (frame_index == LAST_FRAME) begin
                                if (LOOP != 0) begin
                                    frame_index <= '0;
                                end else begin
                                    state     <= DONE;
                                    anim_done <= 1'b1;
                                end
                            end else begin
                                frame_index <= frame_index + 1'b1;
                            end
                        end else begin
                            hold <= hold + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!bus.enable) begin
                        state       <= IDLE;
                        frame_index <= '0;
                        hold        <= '0;
                        anim_done   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Draw position is sampled once per video frame so the title never tears mid-scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_x <= 32'(DEFAULT_X);
            lat_y <= 32'(DEFAULT_Y);
        end else if (bus.frame_start) begin
            lat_x <= bus.pos_x;
            lat_y <= bus.pos_y;
        end
    end

    // Stage 0: pixel position relative to the title origin and the RAM word it maps to.
    always_comb begin
        adj_row   = bus.pixel_row - lat_y;
        adj_col   = bus.pixel_column - lat_x;
        in_bounds = (adj_row >= 32'sd0) && (adj_row < TITLE_H) &&
                    (adj_col >= 32'sd0) && (adj_col < TITLE_W);
        read_addr = {frame_index, adj_row[TITLE_ADDR_WIDTH_Y-1:0], adj_col[TITLE_ADDR_WIDTH_X-1:0]};
    end

    // Stage 1: synchronous RAM read (no reset so it maps onto block RAM).
    always_ff @(posedge clk) begin
        q <= mem[read_addr];
    end

    // Stage 1: bounds flag travels with the RAM read.
    always_ff @(posedge clk) begin
        if (reset) s1_in_bounds <= 1'b0;
        else       s1_in_bounds <= in_bounds;
    end

`ifdef TITLE_BLINK_EN
    localparam int BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    logic [BLINK_W-1:0] blink_cnt;

    // Blink phase counts video frames while playing; second half of the period is blanked.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            blink_cnt <= '0;
        end else if (bus.frame_start) begin
            blink_cnt <= (blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) ? '0 : blink_cnt + 1'b1;
        end
    end
    assign blink_off = (blink_cnt >= BLINK_W'(BLINK_PERIOD / 2));
`else
    localparam int unused_blink_period = BLINK_PERIOD;
    assign blink_off = 1'b0;
`endif

    // Stage 2 decision: opaque, in-bounds, and the animation is running.
    always_comb begin
        valid_next = s1_in_bounds && (q != TRANSPARENT_COLOR) && (state != IDLE) && !blink_off;
    end

    // Stage 2: registered output to the display mux; non-title pixels are forced black.
    always_ff @(posedge clk) begin
        if (reset) begin
            title_valid <= 1'b0;
            title_color <= 12'h000;
        end else begin
            title_valid <= valid_next;
            title_color <= valid_next ? q : 12'h000;
        end
    end

    assign bus.title_color = title_color;
    assign bus.title_valid = title_valid;
    assign bus.frame_index = frame_index;
    assign bus.anim_done   = anim_done;
endmodule

// File: tb/tb_anim_title_colorizer.sv
module tb_anim_title_colorizer;
    localparam int NF          = 4;
    localparam int HOLD        = 8;
    localparam int TW          = 256;
    localparam int TH          = 128;
    localparam int FRAME_WORDS = TW * TH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    anim_title_colorizer_if #(.FRAME_ADDR_WIDTH(2)) bus  ();
    anim_title_colorizer_if #(.FRAME_ADDR_WIDTH(2)) bus0 ();
    anim_title_colorizer_if #(.FRAME_ADDR_WIDTH(1)) bus1 ();

    assign bus0.enable       = bus.enable;
    assign bus0.frame_start  = bus.frame_start;
    assign bus0.pos_x        = bus.pos_x;
    assign bus0.pos_y        = bus.pos_y;
    assign bus0.pixel_row    = bus.pixel_row;
    assign bus0.pixel_column = bus.pixel_column;
    assign bus1.enable       = bus.enable;
    assign bus1.frame_start  = bus.frame_start;
    assign bus1.pos_x        = bus.pos_x;
    assign bus1.pos_y        = bus.pos_y;
    assign bus1.pixel_row    = bus.pixel_row;
    assign bus1.pixel_column = bus.pixel_column;

    anim_title_colorizer #(.INIT_FILE(""), .LOOP(1)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    anim_title_colorizer #(.INIT_FILE(""), .LOOP(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    anim_title_colorizer #(.INIT_FILE(""), .LOOP(0), .NUM_FRAMES(1),
                           .FRAME_ADDR_WIDTH(1), .FRAME_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    int errors = 0;
    int checks = 0;
    int pulses;          // frame_start pulses seen while playing
    int lat_x, lat_y;    // model of the latched draw position
    logic [12:0] expq[$];

    // Reference picture content: a scrambled value per address, transparent at word 5 of every frame.
    function automatic logic [11:0] word(int a);
        int t;
        if ((a % FRAME_WORDS) == 5) return 12'hF0F;
        t = a * 29 + (a / FRAME_WORDS) * 32'h351 + 32'h123;
        return t[11:0];
    endfunction

    function automatic bit blink_off_m(int n);
`ifdef TITLE_BLINK_EN
        return (n % 32) >= 16;
`else
        return (n < 0);
`endif
    endfunction

    // {valid, colour} expected for a pixel given the animation frame currently shown.
    function automatic logic [12:0] model_pix(int row, int col, int idx, bit active, bit blank);
        int ar, ac;
        logic [11:0] w;
        ar = row - lat_y;
        ac = col - lat_x;
        if (!active || blank || ar < 0 || ar >= TH || ac < 0 || ac >= TW) return 13'h0;
        w = word(idx * FRAME_WORDS + ar * TW + ac);
        if (w == 12'hF0F) return 13'h0;
        return {1'b1, w};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input logic v, input logic [11:0] c, input logic [12:0] e);
        chk({tag, ".valid"}, 32'(v), 32'(e[12]));
        chk({tag, ".color"}, 32'(c), 32'(e[11:0]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int row, input int col);
        bus.pixel_row    = row;
        bus.pixel_column = col;
    endtask

    task automatic pulse();
        bus.frame_start = 1'b1;
        lat_x = bus.pos_x;
        lat_y = bus.pos_y;
        if (bus.enable) pulses++;
        step();
        bus.frame_start = 1'b0;
    endtask

    task automatic check_anim(input string tag);
        int il, is;
        bit bo;
        il = (pulses / HOLD) % NF;
        is = (pulses >= HOLD * NF) ? NF - 1 : pulses / HOLD;
        bo = blink_off_m(pulses);
        chk({tag, ".idx"},   32'(bus.frame_index),  32'(il));
        chk({tag, ".idx0"},  32'(bus0.frame_index), 32'(is));
        chk({tag, ".done0"}, 32'(bus0.anim_done),   32'(pulses >= HOLD * NF));
        chk({tag, ".idx1"},  32'(bus1.frame_index), 32'(0));
        chk({tag, ".done1"}, 32'(bus1.anim_done),   32'(pulses >= 1));
        chk_pix({tag, ".pix"}, bus.title_valid, bus.title_color,
                model_pix(bus.pixel_row, bus.pixel_column, il, 1'b1, bo));
        chk_pix({tag, ".pix0"}, bus0.title_valid, bus0.title_color,
                model_pix(bus.pixel_row, bus.pixel_column, is, 1'b1, bo));
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.frame_start = 1'b0;
        bus.pos_x = 384;
        bus.pos_y = 32;
        set_pix(32, 384);
        for (int a = 0; a < NF * FRAME_WORDS; a++) begin
            dut.mem[a]  = word(a);
            dut0.mem[a] = word(a);
        end
        lat_x = 384;
        lat_y = 32;
        pulses = 0;

        // Reset state
        step();
        step();
        chk_pix("rst", bus.title_valid, bus.title_color, 13'h0);
        chk_pix("rst0", bus0.title_valid, bus0.title_color, 13'h0);
        chk_pix("rst1", bus1.title_valid, bus1.title_color, 13'h0);
        chk("rst.idx", 32'(bus.frame_index), 32'(0));
        chk("rst.done0", 32'(bus0.anim_done), 32'(0));
        chk("rst.done1", 32'(bus1.anim_done), 32'(0));

        // Start playing at the default position; origin pixel reads frame 0 word 0
        reset = 1'b0;
        bus.enable = 1'b1;
        step(); step(); step();
        chk_pix("origin", bus.title_valid, bus.title_color, model_pix(32, 384, 0, 1'b1, 1'b0));
        chk("origin.word0", 32'(bus.title_color), 32'h123);
        set_pix(31, 384);
        step(); step();
        chk_pix("above", bus.title_valid, bus.title_color, model_pix(31, 384, 0, 1'b1, 1'b0));
        set_pix(32, 389);
        step(); step();
        chk_pix("transparent", bus.title_valid, bus.title_color, 13'h0);

        // Streaming random pixels, one per clock, checked 2 clocks later
        for (int i = 0; i < 200; i++) begin
            int r, c;
            r = int'($urandom_range(220)) - 20;
            c = 300 + int'($urandom_range(340));
            set_pix(r, c);
            expq.push_back(model_pix(r, c, 0, 1'b1, 1'b0));
            step();
            if (expq.size() == 2) chk_pix("stream", bus.title_valid, bus.title_color, expq.pop_front());
        end
        step();
        chk_pix("stream.last", bus.title_valid, bus.title_color, expq.pop_front());

        // Frame stepping: 42 pulses covering wrap (LOOP=1) and DONE hold (LOOP=0)
        set_pix(32, 384);
        for (int p = 0; p < 42; p++) begin
            pulse();
            step(); step();
            check_anim("anim");
        end

        // Position changes only take effect at the next frame_start
        bus.pos_x = 0;
        bus.pos_y = 0;
        step(); step();
        chk_pix("nolatch.old", bus.title_valid, bus.title_color,
                model_pix(32, 384, (pulses / HOLD) % NF, 1'b1, blink_off_m(pulses)));
        set_pix(0, 0);
        step(); step();
        chk_pix("nolatch.new", bus.title_valid, bus.title_color, 13'h0);
        pulse();
        step(); step();
        check_anim("latch00");
        bus.pos_x = -10;
        bus.pos_y = -5;
        pulse();
        step(); step();
        check_anim("latchneg");

        // Title edges with the title partly off-screen
        begin
            int edge_rows [4] = '{122, 123, 0, -6};
            int edge_cols [4] = '{245, 0, 246, 0};
            for (int k = 0; k < 4; k++) begin
                set_pix(edge_rows[k], edge_cols[k]);
                step(); step();
                check_anim("edge");
            end
        end

        // enable falling together with frame_start: idle wins, no advance
        set_pix(0, 0);
        bus.enable = 1'b0;
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        pulses = 0;
        chk("dis.idx", 32'(bus.frame_index), 32'(0));
        chk("dis.idx0", 32'(bus0.frame_index), 32'(0));
        chk("dis.done0", 32'(bus0.anim_done), 32'(0));
        step(); step();
        chk_pix("dis.pix", bus.title_valid, bus.title_color, 13'h0);

        // Replay partway, then reset mid-animation
        bus.enable = 1'b1;
        step();
        for (int p = 0; p < 20; p++) begin
            pulse();
            step(); step();
            check_anim("replay");
        end
        reset = 1'b1;
        step();
        pulses = 0;
        lat_x = 384;
        lat_y = 32;
        chk_pix("midrst", bus.title_valid, bus.title_color, 13'h0);
        chk("midrst.idx", 32'(bus.frame_index), 32'(0));
        chk("midrst.idx0", 32'(bus0.frame_index), 32'(0));
        reset = 1'b0;
        set_pix(32, 384);
        step(); step(); step();
        chk_pix("postrst", bus.title_valid, bus.title_color, model_pix(32, 384, 0, 1'b1, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/anim_title_colorizer.md
Name: anim_title_colorizer

Overview:
- Parametrised, animated successor to the static title colorizer.
- Stores NUM_FRAMES title frames in one block RAM and steps through them on video-frame ticks from the dtg.
- Title is drawn at a run-time position latched once per video frame; a key colour is treated as transparent.
- Feeds the display mux with a colour plus valid flag, pipeline-aligned to the RAM read latency.

Parameters:
INIT_FILE, "title-anim.mem", RAM init file, frames stored consecutively
TITLE_ADDR_WIDTH_X, 8, column address bits; TITLE_WIDTH = 2^this
TITLE_ADDR_WIDTH_Y, 7, row address bits; TITLE_HEIGHT = 2^this
NUM_FRAMES, 4, animation frame count, 1..16
FRAME_ADDR_WIDTH, 2, frame index bits, >= clog2(NUM_FRAMES), min 1
FRAME_HOLD, 8, video frames each animation frame is shown, >= 1
LOOP, 1, 1 = wrap to frame 0 after last; 0 = stop on last frame
TRANSPARENT_COLOR, 12'hF0F, RAM colour rendered as not-valid
DEFAULT_X, 384, position after reset
DEFAULT_Y, 32, position after reset
BLINK_PERIOD, 32, video frames per blink cycle (TITLE_BLINK_EN only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  1 = animate and draw; 0 = idle, output blank
frame_start  in  1  one-cycle pulse at start of each video frame (vsync)
pos_x  in  32 signed  requested title left edge
pos_y  in  32 signed  requested title top edge
pixel_row  in  32 signed  dtg pixel row
pixel_column  in  32 signed  dtg pixel column
title_color  out  12  colour for pixel presented 2 cycles earlier
title_valid  out  1  1 = title_color is opaque title pixel
frame_index  out  FRAME_ADDR_WIDTH  current animation frame
anim_done  out  1  1 in DONE state (LOOP=0 only)

Behaviour:
- Reset (sync, priority over all): state IDLE, frame_index 0, hold count 0, latched pos = DEFAULT_X/DEFAULT_Y, title_color 12'h000, title_valid 0, anim_done 0, pipeline valid bits cleared.
- Position latch: pos_x/pos_y captured only on frame_start (any state), so a frame never tears mid-scan.
- Pixel pipeline, latency exactly 2 clk:
  - Cycle 0: adj_row = pixel_row - lat_y, adj_col = pixel_column - lat_x (32-bit signed); in_bounds = 0 <= adj_row < TITLE_HEIGHT and 0 <= adj_col < TITLE_WIDTH.
  - read_addr = {frame_index, adj_row[Y-1:0], adj_col[X-1:0]}; RAM registers it at edge 1.
  - in_bounds registered alongside (stage-1).
  - Edge 2: title_valid <= stage1_in_bounds && q != TRANSPARENT_COLOR && state != IDLE; title_color <= title_valid_next ? q : 12'h000.
- FSM:
  - IDLE: enable=0 forces here from any state next cycle; frame_index 0, hold 0. Enable=1 -> PLAY.
  - PLAY: on frame_start, hold increments; when hold == FRAME_HOLD-1 and frame_start, hold <= 0 and frame_index advances.
    - At NUM_FRAMES-1 with LOOP=1: wraps to 0.
    - At NUM_FRAMES-1 with LOOP=0: moves to DONE.
  - DONE: frame_index held at NUM_FRAMES-1, anim_done=1, still draws; enable=0 -> IDLE.
- Edge cases:
  - NUM_FRAMES=1: index stays 0; LOOP=0 enters DONE after FRAME_HOLD frames.
  - FRAME_HOLD=1: advance on every frame_start.
  - frame_start and enable falling edge in the same cycle: IDLE wins, no advance.
  - frame_index changes only on frame_start, so it is stable across a scan.
  - Negative pos or pixel coordinates are legal; pixels outside the title are not valid.

Optional Feature:
- TITLE_BLINK_EN defined:
  - blink counter counts frame_start pulses modulo BLINK_PERIOD; reset and IDLE clear it.
  - title_valid forced 0 (colour 000) while count >= BLINK_PERIOD/2.
- Undefined: no blink counter, title always visible when valid.

Test Plan:
- Reset, enable=1, pos (384,32), pixel (32,384) held -> 2 clk later title_color = RAM[0], title_valid=1; pixel (31,384) -> valid 0, colour 000.
- Frame 0 word at addr 5 = 12'hF0F, pixel (32,389) -> title_valid 0, title_color 000.
- LOOP=1, FRAME_HOLD=8, NUM_FRAMES=4: 32 frame_start pulses -> frame_index 0,1,2,3 each held 8 pulses, then back to 0; pixel (32,384) reads addr {idx,0,0}.
- LOOP=0: after 32 pulses -> anim_done=1, frame_index=3, stays 3 after 10 more pulses; enable=0 -> IDLE, index 0 next cycle.
- pos changed to (0,0) mid-frame -> draw position unchanged until next frame_start; pixel (0,0) valid after it; pos (-10,-5), pixel (0,0) -> reads row 5, col 10.
- TITLE_BLINK_EN, BLINK_PERIOD=32: pulses 16..31 -> title_valid 0 on in-bounds opaque pixels; pulses 0..15 and 32 -> valid 1; reset asserted mid-blink -> counter 0, outputs 0 next cycle.
